// File: rtl/computer_run_checker.sv
// Run controller and write-stream checker beside the 16-bit single-cycle computer.
// Latency: verdict and match_count update 1 cycle after the deciding write; CPU reset held RESET_CYCLES.
// Backpressure: none; observes the write bus passively and freezes the CPU clock once a verdict is reached.
module computer_run_checker #(
  parameter int N            = 16,
  parameter int CHECKS       = 4,
  parameter int TIMEOUT      = 1024,
  parameter int RESET_CYCLES = 2,
  parameter int ORDERED      = 1,
  localparam int IW = (CHECKS > 1) ? $clog2(CHECKS) : 1,
  localparam int CW = $clog2(TIMEOUT + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          exp_load,
  input  logic          exp_clear,
  input  logic [IW-1:0] exp_idx,
  input  logic [N-1:0]  exp_addr,
  input  logic [N-1:0]  exp_data,
  input  logic          memwrite,
  input  logic [N-1:0]  dataadr,
  input  logic [N-1:0]  writedata,
  output logic          cpu_reset,
  output logic          clk_enable,
  output logic          busy,
  output logic          pass,
  output logic          fail,
  output logic          timeout,
  output logic [IW:0]   match_count,
  output logic [CW-1:0] cycle_count,
  output logic [N-1:0]  fail_addr,
  output logic [N-1:0]  fail_data
);

  localparam int RW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

  typedef enum logic [2:0] {IDLE, RST, RUN, PASS, FAIL, TOUT} state_t;

  state_t            state, state_nxt;
  logic [N-1:0]      tbl_addr [CHECKS];
  logic [N-1:0]      tbl_data [CHECKS];
  logic [CHECKS-1:0] valid, valid_nxt;
  logic [CHECKS-1:0] matched, matched_nxt;
  logic [CHECKS-1:0] hit_vec;
  logic [RW-1:0]     rst_cnt;
  logic              idle_like, start_run, load_ok, found, miss, all_done;

  assign idle_like = (state == IDLE) || (state == PASS) || (state == FAIL) || (state == TOUT);
  assign start_run = idle_like && start;
  assign load_ok   = exp_load && (int'(exp_idx) < CHECKS);

  // Table edits: a same-cycle clear wipes the old entries before the load lands.
  always_comb begin
    valid_nxt = exp_clear ? '0 : valid;
    if (load_ok) valid_nxt[exp_idx] = 1'b1;
  end

  // Unordered mode only considers entries whose address matches the write.
  always_comb begin
    hit_vec = '0;
    miss    = 1'b0;
    found   = 1'b0;
    for (int i = 0; i < CHECKS; i++) begin
      if (!found && valid[i] && !matched[i] && ((ORDERED != 0) || (tbl_addr[i] == dataadr))) begin
        found = 1'b1;
        if ((tbl_addr[i] == dataadr) && (tbl_data[i] == writedata)) hit_vec[i] = 1'b1;
        else                                                         miss       = 1'b1;
      end
    end
    if ((state != RUN) || !memwrite) begin
      hit_vec = '0;
      miss    = 1'b0;
    end
  end

  assign matched_nxt = matched | hit_vec;
  assign all_done    = &(matched_nxt | ~valid);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, PASS, FAIL, TOUT: if (start) state_nxt = RST;
      RST:  if (rst_cnt == RW'(RESET_CYCLES - 1)) state_nxt = RUN;
      RUN: begin
        if (miss)                                   state_nxt = FAIL;
        else if (all_done)                          state_nxt = PASS;
        else if (cycle_count == CW'(TIMEOUT - 1))   state_nxt = TOUT;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign cpu_reset  = (state != RUN);
  assign clk_enable = (state == RST) || (state == RUN);
  assign busy       = clk_enable;
  assign pass       = (state == PASS);
  assign fail       = (state == FAIL);
  assign timeout    = (state == TOUT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      rst_cnt     <= '0;
      cycle_count <= '0;
      match_count <= '0;
      matched     <= '0;
      valid       <= '0;
      fail_addr   <= '0;
      fail_data   <= '0;
    end else begin
      state <= state_nxt;
      if (idle_like) valid <= valid_nxt;
      if (start_run) begin
        rst_cnt     <= '0;
        cycle_count <= '0;
        match_count <= '0;
        matched     <= '0;
        fail_addr   <= '0;
        fail_data   <= '0;
      end else begin
        if (state == RST) rst_cnt <= rst_cnt + RW'(1);
        if (state == RUN) begin
          if (cycle_count != CW'(TIMEOUT)) cycle_count <= cycle_count + CW'(1);
          matched <= matched_nxt;
          if (|hit_vec) match_count <= match_count + (IW+1)'(1);
          if (miss) begin
            fail_addr <= dataadr;
            fail_data <= writedata;
          end
        end
      end
    end
  end

  // Entry payloads need no reset; the valid bits gate every use.
  always_ff @(posedge clk) begin
    if (idle_like && load_ok) begin
      tbl_addr[exp_idx] <= exp_addr;
      tbl_data[exp_idx] <= exp_data;
    end
  end

endmodule

// File: tb/tb_computer_run_checker.sv
// Directed bench: one ordered and one unordered checker share the stimulus, TIMEOUT = 16.
module tb_computer_run_checker;

  logic        clk = 1'b0;
  logic        reset, start, exp_load, exp_clear, memwrite;
  logic [1:0]  exp_idx;
  logic [15:0] exp_addr, exp_data, dataadr, writedata;

  logic        cr1, ce1, bz1, ps1, fl1, to1;
  logic [2:0]  mc1;
  logic [4:0]  cc1;
  logic [15:0] fa1, fd1;
  logic        cr0, ce0, bz0, ps0, fl0, to0;
  logic [2:0]  mc0;
  logic [4:0]  cc0;
  logic [15:0] fa0, fd0;

  int n_chk = 0;
  int n_ok  = 0;

  always #5 clk = ~clk;

  computer_run_checker #(.N(16), .CHECKS(4), .TIMEOUT(16), .RESET_CYCLES(2), .ORDERED(1)) u_ord (
    .clk(clk), .reset(reset), .start(start), .exp_load(exp_load), .exp_clear(exp_clear),
    .exp_idx(exp_idx), .exp_addr(exp_addr), .exp_data(exp_data), .memwrite(memwrite),
    .dataadr(dataadr), .writedata(writedata), .cpu_reset(cr1), .clk_enable(ce1), .busy(bz1),
    .pass(ps1), .fail(fl1), .timeout(to1), .match_count(mc1), .cycle_count(cc1),
    .fail_addr(fa1), .fail_data(fd1)
  );

  computer_run_checker #(.N(16), .CHECKS(4), .TIMEOUT(16), .RESET_CYCLES(2), .ORDERED(0)) u_any (
    .clk(clk), .reset(reset), .start(start), .exp_load(exp_load), .exp_clear(exp_clear),
    .exp_idx(exp_idx), .exp_addr(exp_addr), .exp_data(exp_data), .memwrite(memwrite),
    .dataadr(dataadr), .writedata(writedata), .cpu_reset(cr0), .clk_enable(ce0), .busy(bz0),
    .pass(ps0), .fail(fl0), .timeout(to0), .match_count(mc0), .cycle_count(cc0),
    .fail_addr(fa0), .fail_data(fd0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    else             n_ok++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic clr, input logic [1:0] idx, input logic [15:0] a, input logic [15:0] d);
    exp_clear = clr;
    exp_load  = 1'b1;
    exp_idx   = idx;
    exp_addr  = a;
    exp_data  = d;
    tick();
    exp_clear = 1'b0;
    exp_load  = 1'b0;
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [15:0] d);
    memwrite  = 1'b1;
    dataadr   = a;
    writedata = d;
    tick();
    memwrite  = 1'b0;
  endtask

  // start sampled, then two RST cycles; returns in the first RUN cycle
  task automatic run_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; exp_load = 1'b0; exp_clear = 1'b0; memwrite = 1'b0;
    exp_idx = '0; exp_addr = '0; exp_data = '0; dataadr = '0; writedata = '0;

    #12;
    check("rst_cpu_reset", 32'(cr1), 1);
    check("rst_clk_en",    32'(ce1), 0);
    check("rst_busy",      32'(bz1), 0);
    check("rst_verdict",   {29'd0, ps1, fl1, to1}, 0);
    check("rst_counts",    {24'd0, mc1, cc1}, 0);
    check("rst_fail_cap",  {fa1, fd1}, 0);
    reset = 1'b1;
    tick();

    // single expected write, ordered, passes
    load(1'b0, 2'd0, 16'd84, 16'h0096);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("rst1_cpu_reset", 32'(cr1), 1);
    check("rst1_clk_en",    32'(ce1), 1);
    check("rst1_busy",      32'(bz1), 1);
    tick();
    check("rst2_cpu_reset", 32'(cr1), 1);
    tick();
    check("run_cpu_reset",  32'(cr1), 0);
    check("run_cycle0",     32'(cc1), 0);
    repeat (4) tick();
    check("pre_write_cycles", 32'(cc1), 4);
    check("pre_write_pass",   32'(ps1), 0);
    cpu_write(16'd84, 16'h0096);
    check("t1_pass",      32'(ps1), 1);
    check("t1_match",     32'(mc1), 1);
    check("t1_clk_en",    32'(ce1), 0);
    check("t1_cpu_reset", 32'(cr1), 1);
    check("t1_cycles",    32'(cc1), 5);

    // same table, wrong data: fail with capture
    run_start();
    check("t2_cycle_clr", 32'(cc1), 0);
    check("t2_match_clr", 32'(mc1), 0);
    check("t2_pass_clr",  32'(ps1), 0);
    repeat (4) tick();
    cpu_write(16'd84, 16'h0095);
    check("t2_fail",      32'(fl1), 1);
    check("t2_pass",      32'(ps1), 0);
    check("t2_fail_addr", 32'(fa1), 84);
    check("t2_fail_data", 32'(fd1), 16'h0095);
    check("t2_any_fail",  32'(fl0), 1);

    // two entries; clear and load in the same cycle leaves only entry 0
    load(1'b1, 2'd0, 16'd80, 16'd7);
    load(1'b0, 2'd1, 16'd84, 16'h0096);
    run_start();
    check("t3_restart_cycles", 32'(cc1), 0);
    check("t3_restart_fcap",   32'(fa1), 0);
    cpu_write(16'd84, 16'h0096);
    check("t3_ord_fail",      32'(fl1), 1);
    check("t3_ord_fail_addr", 32'(fa1), 84);
    check("t3_ord_fail_data", 32'(fd1), 16'h0096);
    check("t3_any_match1",    32'(mc0), 1);
    check("t3_any_busy1",     32'(bz0), 1);
    cpu_write(16'd60, 16'd1);
    check("t3_any_ignore",    32'(mc0), 1);
    check("t3_any_busy2",     32'(bz0), 1);
    cpu_write(16'd80, 16'd7);
    check("t3_any_pass",      32'(ps0), 1);
    check("t3_any_match2",    32'(mc0), 2);
    check("t3_any_nofail",    32'(fl0), 0);

    // timeout with no writes
    load(1'b1, 2'd0, 16'd84, 16'h0096);
    run_start();
    repeat (15) tick();
    check("t4_pre_tout",  32'(to1), 0);
    check("t4_pre_cyc",   32'(cc1), 15);
    tick();
    check("t4_tout",      32'(to1), 1);
    check("t4_tout_cyc",  32'(cc1), 16);
    check("t4_tout_clk",  32'(ce1), 0);
    tick();
    check("t4_tout_hold", 32'(cc1), 16);

    // final match on the timeout edge wins
    run_start();
    repeat (15) tick();
    cpu_write(16'd84, 16'h0096);
    check("t4_edge_pass", 32'(ps1), 1);
    check("t4_edge_tout", 32'(to1), 0);
    check("t4_edge_cyc",  32'(cc1), 16);

    // mismatch on the timeout edge wins
    run_start();
    repeat (15) tick();
    cpu_write(16'd84, 16'd1);
    check("t4_edge_fail",  32'(fl1), 1);
    check("t4_edge_tout2", 32'(to1), 0);

    // empty table passes one cycle into RUN
    exp_clear = 1'b1;
    tick();
    exp_clear = 1'b0;
    run_start();
    check("t5_run_nopass", 32'(ps1), 0);
    check("t5_run_busy",   32'(bz1), 1);
    tick();
    check("t5_pass",       32'(ps1), 1);
    check("t5_any_pass",   32'(ps0), 1);
    check("t5_cycles",     32'(cc1), 1);

    // asynchronous reset mid-run
    load(1'b0, 2'd0, 16'd84, 16'h0096);
    run_start();
    repeat (3) tick();
    check("t6_pre_busy", 32'(bz1), 1);
    check("t6_pre_cyc",  32'(cc1), 3);
    #1 reset = 1'b0;
    #1;
    check("t6_cpu_reset", 32'(cr1), 1);
    check("t6_clk_en",    32'(ce1), 0);
    check("t6_busy",      32'(bz1), 0);
    check("t6_cycles",    32'(cc1), 0);
    #1 reset = 1'b1;
    tick();
    run_start();
    tick();
    check("t6_table_empty", 32'(ps1), 1);

    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end

endmodule
